// File: rtl/rc5_host_sequencer_pkg.sv
// Shared command codes, FSM encoding and control-strobe bundle for the RC5 host sequencer.
package rc5_host_sequencer_pkg;
  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY, ST_OPND, ST_RUN, ST_SEND, ST_DRAIN
  } seq_state_e;

  typedef enum logic {MODE_ENC, MODE_DEC} seq_mode_e;

  // Per-cycle strobes decoded by the FSM and consumed by the datapath
  typedef struct packed {
    logic key_we;
    logic key_done;
    logic opnd_shift;
    logic res_load;
    logic res_shift;
    logic bad;
    logic mode_set;
  } seq_ctl_t;

  function automatic logic is_op_cmd(input logic [7:0] b);
    return (b == CMD_ENC) || (b == CMD_DEC);
  endfunction
endpackage

// File: rtl/rc5_word_shifter.sv
// Byte-wide shift register: assembles bytes LSB-first into a word, or
// serialises a parallel-loaded word LSB-first (q[7:0] is the next byte out).
module rc5_word_shifter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic [7:0]   in_byte,
  output logic [W-1:0] q
);
  // New bytes enter at the top and walk down, so the first byte ends up lowest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (load)  q <= load_data;
    else if (shift) q <= {in_byte, q[W-1:8]};
  end
endmodule

// File: rtl/rc5_host_sequencer.sv
// Byte-serial host front end for the RC5 core: key load, operand assembly,
// start/done handshake and result serialisation. All outputs registered.
module rc5_host_sequencer
  import rc5_host_sequencer_pkg::*;
#(
  parameter  int W        = 32,
  parameter  int B        = 16,
  localparam int C        = W / 8,
  localparam int B_LENGTH = $clog2(B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          iData,
  input  logic                iValid,
  output logic                oReady,
  output logic [7:0]          oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBadCmd,
  output logic [7:0]          oKey_sub_i,
  output logic [B_LENGTH-1:0] oKey_address,
  output logic                oWen,
  output logic                oStartCipher,
  output logic                oStartDecipher,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  input  logic [W-1:0]        iA_res,
  input  logic [W-1:0]        iB_res,
  input  logic                iDone
);
  localparam int NB   = 2 * C;
  localparam int BC_W = $clog2(NB);
  localparam logic [B_LENGTH-1:0] KEY_LAST  = B_LENGTH'(B - 1);
  localparam logic [BC_W-1:0]     BYTE_LAST = BC_W'(NB - 1);

  seq_state_e            state, state_n;
  seq_ctl_t              ctl;
  seq_mode_e             mode;
  logic                  key_loaded;
  logic [B_LENGTH-1:0]   key_cnt;
  logic [BC_W-1:0]       byte_cnt;
  logic [2*W-1:0]        opnd_q, res_q;
  logic                  accept, out_take;

  assign accept   = iValid && oReady;
  assign out_take = oValid && iReady;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_n = state;
    ctl     = '0;
    case (state)
      ST_IDLE: if (accept) begin
        if (iData == CMD_KEY) state_n = ST_KEY;
        else if (is_op_cmd(iData) && key_loaded) begin
          state_n      = ST_OPND;
          ctl.mode_set = 1'b1;
        end else ctl.bad = 1'b1;
      end
      ST_KEY: if (accept) begin
        ctl.key_we = 1'b1;
        if (key_cnt == KEY_LAST) begin
          ctl.key_done = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      ST_OPND: if (accept) begin
        ctl.opnd_shift = 1'b1;
        if (byte_cnt == BYTE_LAST) state_n = ST_RUN;
      end
      ST_RUN: if (iDone) begin
        ctl.res_load = 1'b1;
        state_n      = ST_SEND;
      end
      ST_SEND: if (out_take) begin
        ctl.res_shift = 1'b1;
        if (byte_cnt == BYTE_LAST) state_n = ST_DRAIN;
      end
      // A done left high from the finished run must fall before the next command
      ST_DRAIN: if (!iDone) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Key/byte counters, mode and key_loaded flag; counters restart on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_cnt    <= '0;
      byte_cnt   <= '0;
      mode       <= MODE_ENC;
      key_loaded <= 1'b0;
    end else begin
      if (state_n != ST_KEY) key_cnt <= '0;
      else if (ctl.key_we)   key_cnt <= key_cnt + 1'b1;
      if (state_n != state)                    byte_cnt <= '0;
      else if (ctl.opnd_shift || ctl.res_shift) byte_cnt <= byte_cnt + 1'b1;
      if (ctl.mode_set) mode <= (iData == CMD_DEC) ? MODE_DEC : MODE_ENC;
      if (ctl.key_done) key_loaded <= 1'b1;
    end
  end

  // Registered outputs, decoded from the next state so they appear on state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oReady         <= 1'b0;
      oValid         <= 1'b0;
      oBadCmd        <= 1'b0;
      oWen           <= 1'b0;
      oKey_sub_i     <= '0;
      oKey_address   <= '0;
      oStartCipher   <= 1'b0;
      oStartDecipher <= 1'b0;
    end else begin
      oReady         <= (state_n == ST_IDLE) || (state_n == ST_KEY) || (state_n == ST_OPND);
      oValid         <= (state_n == ST_SEND);
      oBadCmd        <= ctl.bad;
      oWen           <= ctl.key_we;
      oStartCipher   <= (state_n == ST_RUN) && (mode == MODE_ENC);
      oStartDecipher <= (state_n == ST_RUN) && (mode == MODE_DEC);
      if (ctl.key_we) begin
        oKey_sub_i   <= iData;
        oKey_address <= key_cnt;
      end
    end
  end

  rc5_word_shifter #(.W(2*W)) u_opnd (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(ctl.opnd_shift), .in_byte(iData), .q(opnd_q)
  );

  rc5_word_shifter #(.W(2*W)) u_res (
    .clk(clk), .rst(rst), .load(ctl.res_load), .load_data({iB_res, iA_res}),
    .shift(ctl.res_shift), .in_byte(8'h00), .q(res_q)
  );

  assign oA    = opnd_q[W-1:0];
  assign oB    = opnd_q[2*W-1:W];
  assign oData = res_q[7:0];
endmodule
